// File: rtl/ins_encode_if.sv
// ins_encode_if: request and program-memory write bundle for the instruction encoder
interface ins_encode_if #(parameter int ADDR_W = 8);
  logic req_valid, req_ready;
  logic [15:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic rewind;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic err, full, halted;
  modport master (
    output req_valid, op, rd, rs, imm, rewind,
    input  req_ready, mem_we, mem_addr, mem_wdata, err, full, halted
  );
  modport slave (
    input  req_valid, op, rd, rs, imm, rewind,
    output req_ready, mem_we, mem_addr, mem_wdata, err, full, halted
  );
endinterface

// File: rtl/ins_encode.sv
// ins_encode: builds 8-bit instruction bytes from one-hot op requests and writes them to program memory
module ins_encode #(
  parameter int ADDR_W = 8,
  parameter int BASE_ADDR = 0,
  parameter int LAST_ADDR = 255
) (
  input logic clk,
  input logic rst,
  ins_encode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_t;
  localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(LAST_ADDR);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  state_t state, state_nx;
  logic [ADDR_W:0] ptr;
  logic [7:0] imm_q, b0;
  logic two_q, halt_q, two, bad, accept;
  always_comb begin
    b0 = 8'h00;
    two = 1'b0;
    bad = 1'b0;
    case (bus.op)
      16'h8000: begin b0 = {4'hC, bus.rd, bus.rs}; bad = bus.rd == 2'b11 || bus.rs == 2'b11; end
      16'h4000: begin b0 = {6'b110011, bus.rs}; bad = bus.rs == 2'b11; end
      16'h2000: begin b0 = {4'hC, bus.rd, 2'b11}; bad = bus.rd == 2'b11; end
      16'h1000: b0 = {4'h9, bus.rd, bus.rs};
      16'h0800: b0 = {4'h6, bus.rd, bus.rs};
      16'h0400: b0 = {4'hB, bus.rd, bus.rs};
      16'h0200: b0 = {4'h5, bus.rd, 2'b00};
      16'h0100: b0 = {4'hA, bus.rd, 2'b00};
      16'h0080: b0 = {4'hA, bus.rd, 2'b11};
      16'h0040: begin b0 = 8'h30; two = 1'b1; end
      16'h0020: begin b0 = 8'h34; two = 1'b1; end
      16'h0010: begin b0 = 8'h38; two = 1'b1; end
      16'h0008: b0 = {4'h2, bus.rd, 2'b00};
      16'h0004: b0 = {6'b010000, bus.rs};
      16'h0002: b0 = 8'h70;
      16'h0001: b0 = 8'h80;
      default:  bad = 1'b1;
    endcase
    // a two-byte op must not be split across the end of the region
    bad = bad || (two && ptr == LAST);
    accept = bus.req_valid && bus.req_ready && !bus.rewind;
    state_nx = state == IDLE ? (accept && !bad ? EMIT0 : IDLE) :
               state == EMIT0 && two_q ? EMIT1 : IDLE;
  end
  assign bus.req_ready = state == IDLE && !bus.full && !bus.halted && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= BASE;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= BASE_A;
      bus.mem_wdata <= 8'h00;
      bus.err <= 1'b0;
      bus.full <= 1'b0;
      bus.halted <= 1'b0;
      imm_q <= 8'h00;
      two_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      state <= state_nx;
      bus.mem_we <= 1'b0;
      bus.err <= 1'b0;
      if (state == IDLE && bus.rewind) begin
        ptr <= BASE;
        bus.full <= 1'b0;
        bus.halted <= 1'b0;
      end else if (accept) begin
        bus.err <= bad;
        if (!bad) begin
          bus.mem_we <= 1'b1;
          bus.mem_addr <= ptr[ADDR_W-1:0];
          bus.mem_wdata <= b0;
          imm_q <= bus.imm;
          two_q <= two;
          halt_q <= bus.op == 16'h0001;
        end
      end
      if (state != IDLE) begin
        ptr <= ptr + ONE;
        bus.full <= ptr + ONE == LAST + ONE;
      end
      if (state == EMIT0) begin
        bus.halted <= halt_q;
        if (two_q) begin
          bus.mem_we <= 1'b1;
          bus.mem_addr <= ptr[ADDR_W-1:0] + ONE_A;
          bus.mem_wdata <= imm_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_ins_encode.sv
// tb_ins_encode: randomized and directed checks of ins_encode against a table-driven encoding model
module tb_ins_encode;
  localparam int LAST = 15;
  localparam logic [7:0] OPC [16] = '{8'h80, 8'h70, 8'h40, 8'h20, 8'h38, 8'h34, 8'h30, 8'hA3,
                                       8'hA0, 8'h50, 8'hB0, 8'h60, 8'h90, 8'hC3, 8'hCC, 8'hC0};
  localparam logic [15:0] RD_USED = 16'hBF88;
  localparam logic [15:0] RS_USED = 16'hDC04;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  int mptr = 0;
  bit mfull = 0, mhalted = 0;
  logic [7:0] last_b0 = 8'h00;
  ins_encode_if #(.ADDR_W(8)) b ();
  ins_encode #(.ADDR_W(8), .BASE_ADDR(0), .LAST_ADDR(LAST)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit encode(input logic [15:0] o, input logic [1:0] d, input logic [1:0] s,
                                output logic [7:0] byte0, output bit two);
    int idx = -1, cnt = 0;
    for (int i = 0; i < 16; i++) if (o[i]) begin cnt++; idx = i; end
    byte0 = 8'h00;
    two = 0;
    if (cnt != 1) return 0;
    byte0 = OPC[idx] | (RD_USED[idx] ? {4'h0, d, 2'b00} : 8'h00) | (RS_USED[idx] ? {6'h0, s} : 8'h00);
    two = idx >= 4 && idx <= 6;
    if (idx == 15 && (d == 2'd3 || s == 2'd3)) return 0;
    if (idx == 14 && s == 2'd3) return 0;
    if (idx == 13 && d == 2'd3) return 0;
    if (two && mptr == LAST) return 0;
    return 1;
  endfunction
  task automatic send(input logic [15:0] o, input logic [1:0] d, input logic [1:0] s, input logic [7:0] im);
    logic [7:0] eb;
    bit two, ok, rdy;
    rdy = !mfull && !mhalted;
    b.req_valid = 1'b1; b.op = o; b.rd = d; b.rs = s; b.imm = im;
    #1 check("req_ready", b.req_ready, rdy);
    ok = encode(o, d, s, eb, two);
    @(negedge clk);
    b.req_valid = 1'b0;
    if (!rdy) begin
      check("blocked_we", b.mem_we, 0);
      check("blocked_err", b.err, 0);
      return;
    end
    if (!ok) begin
      check("reject_err", b.err, 1);
      check("reject_we", b.mem_we, 0);
      return;
    end
    check("b0_we", b.mem_we, 1);
    check("b0_addr", b.mem_addr, mptr);
    check("b0_data", b.mem_wdata, eb);
    check("b0_err", b.err, 0);
    check("busy_ready", b.req_ready, 0);
    last_b0 = b.mem_wdata;
    mptr++;
    if (two) begin
      @(negedge clk);
      check("b1_we", b.mem_we, 1);
      check("b1_addr", b.mem_addr, mptr);
      check("b1_data", b.mem_wdata, im);
      mptr++;
    end
    mfull = mptr == LAST + 1;
    mhalted = mhalted || o == 16'h0001;
    @(negedge clk);
    check("idle_we", b.mem_we, 0);
    check("full", b.full, mfull);
    check("halted", b.halted, mhalted);
    check("idle_ready", b.req_ready, !mfull && !mhalted);
  endtask
  task automatic rewind(input bit with_req);
    b.rewind = 1'b1;
    b.req_valid = with_req;
    b.op = 16'h0002;
    @(negedge clk);
    b.rewind = 1'b0;
    b.req_valid = 1'b0;
    check("rw_we", b.mem_we, 0);
    check("rw_err", b.err, 0);
    check("rw_full", b.full, 0);
    check("rw_halted", b.halted, 0);
    mptr = 0; mfull = 0; mhalted = 0;
  endtask
  initial begin
    logic [15:0] o;
    b.req_valid = 1'b0; b.op = 16'h0; b.rd = 2'd0; b.rs = 2'd0; b.imm = 8'h0; b.rewind = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", b.mem_we, 0);
    check("rst_err", b.err, 0);
    check("rst_full", b.full, 0);
    check("rst_halted", b.halted, 0);
    check("rst_addr", b.mem_addr, 0);
    check("rst_ready_in_rst", b.req_ready, 0);
    rst = 1'b0;
    #1 check("rst_ready", b.req_ready, 1);
    send(16'h1000, 2'b01, 2'b10, 8'h00);
    check("add_byte", last_b0, 8'h96);
    send(16'h0020, 2'b00, 2'b00, 8'h3A);
    check("jz_byte", last_b0, 8'h34);
    send(16'h4000, 2'b00, 2'b01, 8'h00);
    check("movb_byte", last_b0, 8'hCD);
    send(16'h2000, 2'b10, 2'b00, 8'h00);
    check("movc_byte", last_b0, 8'hCB);
    send(16'h8000, 2'b11, 2'b00, 8'h00);
    send(16'h1800, 2'b01, 2'b01, 8'h00);
    send(16'h0000, 2'b00, 2'b00, 8'h00);
    send(16'h0002, 2'b00, 2'b00, 8'h00);
    check("ptr_after_rejects", b.mem_addr, 5);
    b.req_valid = 1'b1; b.op = 16'h0010; b.imm = 8'h55;
    @(negedge clk);
    b.req_valid = 1'b0;
    check("jc_b0_we", b.mem_we, 1);
    check("jc_b0_data", b.mem_wdata, 8'h38);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_emit_we", b.mem_we, 0);
    @(negedge clk);
    check("rst_mid_emit_we2", b.mem_we, 0);
    mptr = 0; mfull = 0; mhalted = 0;
    for (int i = 0; i < LAST; i++) send(16'h0002, 2'b00, 2'b00, 8'h00);
    send(16'h0040, 2'b00, 2'b00, 8'h12);
    send(16'h0002, 2'b00, 2'b00, 8'h00);
    check("fill_addr", b.mem_addr, LAST);
    check("fill_full", b.full, 1);
    send(16'h1000, 2'b00, 2'b00, 8'h00);
    rewind(1'b1);
    send(16'h0001, 2'b00, 2'b00, 8'h00);
    check("halt_byte", last_b0, 8'h80);
    send(16'h0002, 2'b00, 2'b00, 8'h00);
    rewind(1'b0);
    send(16'h0008, 2'b10, 2'b00, 8'h00);
    check("rewind_addr", b.mem_addr, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rewind($urandom_range(0, 1) == 1);
      else begin
        o = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'h1 << $urandom_range(0, 15);
        send(o, 2'($urandom), 2'($urandom), 8'($urandom));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
